// File: rtl/pipelinereg_elastic_pkg.sv
// Shared types and helpers for the elastic pipeline register.
// Both the stage and the top level import this package.
package pipelinereg_elastic_pkg;

  // Decision a single stage takes at the next clock edge.
  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } stage_op_e;

  // Width of a counter that holds the values 0..depth.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage : pipelinereg_elastic_pkg

// File: rtl/pipelinereg_elastic_stage.sv
// One elastic register slot: a valid bit plus a data word. The top level
// computes the ready chain and hands each stage its own ready.
module pipelinereg_elastic_stage
  import pipelinereg_elastic_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             ready,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  stage_op_e        op;

  // Flush outranks every transfer; a ready stage with no upstream data drains.
  always_comb begin
    op = ST_HOLD;
    if (flush)      op = ST_FLUSH;
    else if (ready) op = up_valid ? ST_LOAD : ST_DRAIN;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    unique case (op)
      ST_HOLD:  ;
      ST_LOAD: begin
        v_d = 1'b1;
        d_d = up_data;
      end
      ST_DRAIN: v_d = 1'b0;
      ST_FLUSH: v_d = 1'b0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; the data word is reset as well because its
  // value on reset is visible at out_data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule : pipelinereg_elastic_stage

// File: rtl/pipelinereg_elastic.sv
// Elastic pipeline register: DEPTH valid/data stages with a valid/ready
// handshake on both ends, bubble collapsing and synchronous flush.
module pipelinereg_elastic
  import pipelinereg_elastic_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  input  logic                        flush,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   r;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  // Ready ripples back from the output; a stage is ready if empty or if the
  // stage after it is ready.
  always_comb begin
    r[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r[i] = !v[i] | r[i+1];
    end
  end

  assign in_ready = r[0] & !flush;

  always_comb begin
    up_v[0] = in_valid & in_ready;
    up_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipelinereg_elastic_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .CLK     (CLK),
      .RST     (RST),
      .flush   (flush),
      .up_valid(up_v[i]),
      .up_data (up_d[i]),
      .ready   (r[i]),
      .v       (v[i]),
      .d       (d[i])
    );
  end

  // The flush cycle must not complete an output handshake.
  assign out_valid = v[DEPTH-1] & !flush;
  assign out_data  = d[DEPTH-1];

  // Shifts between stages never change the count; only the two ends do.
  logic             accept, emit;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    occupancy_d = occupancy_q;
    if (flush)              occupancy_d = '0;
    else if (accept & !emit) occupancy_d = occupancy_q + OCC_W'(1);
    else if (emit & !accept) occupancy_d = occupancy_q - OCC_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) occupancy_q <= '0;
    else     occupancy_q <= occupancy_d;
  end

  assign occupancy = occupancy_q;

endmodule : pipelinereg_elastic

// File: doc/pipelinereg_elastic.md
Name: pipelinereg_elastic

Overview:
- Parametrised successor to the fixed single-stage pipeline register.
- Chain of DEPTH data stages, each carrying a valid bit.
- Valid/ready handshake on both ends, bubble collapsing, back-pressure and synchronous flush.
- Sits between datapath stages that can stall independently, such as a fetch-to-decode or memory-response path.

Parameters:
- WIDTH, 32, data bits per stage (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data register on reset.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream presents data
- in_data  input  WIDTH  upstream data
- in_ready  output  1  stage 0 can accept this cycle
- out_valid  output  1  last stage holds valid data
- out_data  output  WIDTH  last-stage data
- out_ready  input  1  downstream accepts this cycle
- flush  input  1  synchronous discard of all contents
- occupancy  output  $clog2(DEPTH+1)  count of valid stages

Behaviour:
- Reset (asynchronous, RST=1):
  - all valid bits are 0 and all data registers equal RESET_VAL.
  - out_valid=0, occupancy=0, out_data=RESET_VAL.
  - in_ready=1 when flush=0.
  - Release is synchronised by the user.
- Stage i holds v[i] and d[i]. Stage DEPTH-1 drives out_valid/out_data directly from registers; there is no combinational path from in_data to out_data.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] | r[i+1].
  - in_ready = r[0] & !flush.
- Transfer into stage i at the edge when the upstream valid is 1 and r[i]=1. The upstream valid is in_valid&in_ready for i=0, or v[i-1] for i>0.
  - On transfer: d[i] takes the upstream data and v[i] is set to 1.
  - If r[i]=1 and the upstream is not valid: v[i] is cleared to 0; d[i] keeps its old value (don't-care).
  - If r[i]=0: the stage holds, d[i] and v[i] unchanged.
- Latency: DEPTH cycles from an accepted input to out_valid with no stall. Throughput: 1 item/cycle.
- Bubble collapsing: an empty stage accepts while later stages stall. DEPTH items can be buffered under back-pressure; stall propagates to in_ready only when all stages are full.
- Output handshake: out_valid and out_data stay stable while out_valid=1 and out_ready=0. Data is never dropped or duplicated.
- Flush (synchronous):
  - in the flush cycle, in_ready=0 and out_valid is forced to 0, so no handshake completes.
  - at the edge, all v[i] clear to 0; data registers are unchanged.
  - flush has priority over every transfer.
- occupancy: registered popcount of v[], updated at the same edge as v[]. Range 0..DEPTH.
- Simultaneous accept and emit when full: legal. Occupancy stays DEPTH and in_ready stays 1 as long as out_ready=1.
- DEPTH=1: degenerates to a single elastic register with combinational in_ready = !v | out_ready.
- Reset mid-operation: all in-flight data is lost immediately; no partial output.

Decomposition:
- No shared package required. Optional: a shared localparam helper for the occupancy width, $clog2(DEPTH+1), if the team's common header provides clog2.
- One natural sub-module: pipelinereg_elastic_stage (WIDTH, RESET_VAL).
  - Inputs: CLK, RST, flush, up_valid, up_data, dn_ready.
  - Outputs: v, d, ready.
  - Instantiated DEPTH times with a generate loop.
- Top level holds the chain, the in_ready gating, the out_valid masking and the occupancy counter.

Test Plan:
1. Streaming: DEPTH=2, out_ready=1, feed 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on cycles 2,3,4 after first accept; in_ready stays 1; occupancy peaks at 2.
2. Back-pressure fill: DEPTH=3, out_ready=0, in_valid=1 with 0xA0..0xA4 → exactly 3 accepted (0xA0–0xA2); in_ready=0 from cycle 3; occupancy=3; out_data holds 0xA0 stable. Then out_ready=1 → 0xA0,0xA1,0xA2 emitted in order with no loss.
3. Bubble collapse: DEPTH=3, one item then idle 2 cycles with out_ready=0 → item reaches stage 2, occupancy=1, in_ready=1. A second item accepted next cycle lands behind it.
4. Flush: pipeline full (occupancy=3), assert flush one cycle with in_valid=1 and out_ready=1 → in_ready=0 and out_valid=0 that cycle; next cycle occupancy=0; no item appears at the output afterwards.
5. Async reset mid-stream: RST pulsed between clock edges while occupancy=2 → out_valid=0, occupancy=0 and out_data=RESET_VAL immediately, without waiting for CLK; streaming resumes correctly after release.
6. Full-throughput at full: DEPTH=2 full, in_valid=1 and out_ready=1 every cycle for 10 cycles → one accept and one emit per cycle, occupancy constant 2, ordering preserved.
